// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULUS up/down counter with sync clear, clamped load and a registered wrap pulse.
// Latency: count and wrap update one edge after qualifying inputs; at_terminal is combinational.
// No backpressure; optional MOD_COUNTER_WRAP_CNT_EN adds a 16-bit saturating wrap_count output.
module mod_counter #(
    parameter int WIDTH       = 3,
    parameter int MODULUS     = 8,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_terminal
`ifdef MOD_COUNTER_WRAP_CNT_EN
    ,
    output logic [15:0]      wrap_count
`endif
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("mod_counter: WIDTH must be >= 1");
        end
        if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
            $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
            $error("mod_counter: RESET_VALUE must be in [0, MODULUS-1]");
        end
    endgenerate

    localparam int unsigned      WP1     = WIDTH + 1;
    localparam logic [WIDTH:0]   MOD_W   = WP1'(MODULUS);
    localparam logic [WIDTH:0]   TERM_W  = WP1'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;

    // Terminal compare is done one bit wider so MODULUS == 2**WIDTH is representable;
    // the +/-1 paths only run off the terminal values, so they never overflow WIDTH bits.
    assign at_max  = ({1'b0, count_q} == TERM_W);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = ({1'b0, load_value} < MOD_W) ? load_value : MAX_VAL;
        end else if (enable) begin
            if (up_down) begin
                if (at_max) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RST_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count       = count_q;
    assign wrap        = wrap_q;
    assign at_terminal = up_down ? at_max : at_zero;

`ifdef MOD_COUNTER_WRAP_CNT_EN
    logic [15:0] wrap_cnt_q, wrap_cnt_d;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clear) begin
            wrap_cnt_d = '0;
        end else if (wrap_d && (wrap_cnt_q != 16'hFFFF)) begin
            wrap_cnt_d = wrap_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_count = wrap_cnt_q;
`endif

endmodule
